// File: rtl/cache_fill_ctrl.sv
// Cache line fill controller: serves read misses and drains a FIFO of evicted dirty lines to memory.
// Build option CACHE_FILL_WB_FWD_EN: hazard misses are answered from the FIFO instead of draining it first.
module cache_fill_ctrl #(
  parameter int LINE_SIZE_BYTES = 4,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int WB_DEPTH        = 4,
  localparam int LINE_SIZE_BITS = 8 * LINE_SIZE_BYTES,
  localparam int PTR_W          = $clog2(WB_DEPTH),
  localparam int CNT_W          = PTR_W + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_miss,
  input  logic [ADDRESS_WIDTH-1:0]  i_miss_addr,
  input  logic                      i_evict,
  input  logic [ADDRESS_WIDTH-1:0]  i_evict_addr,
  input  logic [LINE_SIZE_BITS-1:0] i_evict_data,
  output logic [LINE_SIZE_BITS-1:0] o_memory_line,
  output logic                      o_memory_response,
  output logic                      o_mem_req,
  output logic                      o_mem_we,
  output logic [ADDRESS_WIDTH-1:0]  o_mem_addr,
  output logic [LINE_SIZE_BITS-1:0] o_mem_wdata,
  input  logic                      i_mem_ready,
  input  logic                      i_mem_rvalid,
  input  logic [LINE_SIZE_BITS-1:0] i_mem_rdata,
  output logic [CNT_W-1:0]          o_wb_count,
  output logic                      o_wb_full,
  output logic                      o_wb_empty,
  output logic                      o_busy,
  output logic                      o_wb_overflow
);

  localparam int OFF_W = $clog2(LINE_SIZE_BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RESP, WB_REQ} state_e;

  state_e                    state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]  wbAddr_q [WB_DEPTH];
  logic [LINE_SIZE_BITS-1:0] wbData_q [WB_DEPTH];
  logic [PTR_W-1:0]          head_q, tail_q, scanIdx;
  logic [CNT_W-1:0]          count_q;
  logic                      overflow_q;
  logic [ADDRESS_WIDTH-1:0]  missAddr_q, missAddr_d, missAligned;
  logic [LINE_SIZE_BITS-1:0] line_q, line_d;
  logic                      wbFull, wbEmpty, push, pop, hazard;
`ifdef CACHE_FILL_WB_FWD_EN
  logic [LINE_SIZE_BITS-1:0] fwdData;
`else
  logic                      drain_q, drain_d;
`endif

  assign missAligned = i_miss_addr & ALIGN_MASK;
  assign wbFull      = (count_q == CNT_W'(WB_DEPTH));
  assign wbEmpty     = (count_q == '0);
  assign push        = i_evict && !wbFull;
  assign pop         = (state_q == WB_REQ) && i_mem_ready;

  // Scan oldest to youngest so the last match seen is the youngest copy of the line.
  always_comb begin
    hazard  = 1'b0;
    scanIdx = '0;
`ifdef CACHE_FILL_WB_FWD_EN
    fwdData = '0;
`endif
    for (int k = 0; k < WB_DEPTH; k++) begin
      scanIdx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (wbAddr_q[scanIdx] == missAligned)) begin
        hazard = 1'b1;
`ifdef CACHE_FILL_WB_FWD_EN
        fwdData = wbData_q[scanIdx];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wbAddr_q[tail_q] <= i_evict_addr & ALIGN_MASK;
        wbData_q[tail_q] <= i_evict_data;
        tail_q           <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (i_evict && wbFull) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      missAddr_q <= '0;
      line_q     <= '0;
`ifndef CACHE_FILL_WB_FWD_EN
      drain_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      missAddr_q <= missAddr_d;
      line_q     <= line_d;
`ifndef CACHE_FILL_WB_FWD_EN
      drain_q    <= drain_d;
`endif
    end
  end

  always_comb begin
    state_d           = state_q;
    missAddr_d        = missAddr_q;
    line_d            = line_q;
    o_mem_req         = 1'b0;
    o_mem_we          = 1'b0;
    o_mem_addr        = '0;
    o_mem_wdata       = '0;
    o_memory_response = 1'b0;
`ifndef CACHE_FILL_WB_FWD_EN
    // Once a hazard is seen the whole buffer is drained before the read goes out.
    drain_d           = drain_q && i_miss;
`endif
    case (state_q)
      IDLE: begin
        if (i_miss) begin
`ifdef CACHE_FILL_WB_FWD_EN
          if (hazard) begin
            line_d  = fwdData;
            state_d = RESP;
          end else begin
            missAddr_d = missAligned;
            state_d    = RD_REQ;
          end
`else
          if ((hazard || drain_q) && !wbEmpty) begin
            drain_d = 1'b1;
            state_d = WB_REQ;
          end else begin
            drain_d    = 1'b0;
            missAddr_d = missAligned;
            state_d    = RD_REQ;
          end
`endif
        end else if (!wbEmpty) begin
          state_d = WB_REQ;
        end
      end
      RD_REQ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = missAddr_q;
        if (i_mem_ready) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (i_mem_rvalid) begin
          line_d  = i_mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        o_memory_response = 1'b1;
        state_d           = IDLE;
      end
      WB_REQ: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = wbAddr_q[head_q];
        o_mem_wdata = wbData_q[head_q];
        if (i_mem_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_memory_line = line_q;
  assign o_wb_count    = count_q;
  assign o_wb_full     = wbFull;
  assign o_wb_empty    = wbEmpty;
  assign o_busy        = (state_q != IDLE);
  assign o_wb_overflow = overflow_q;

endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 Parameter LINE_SIZE_BYTES, default 4: cache line size in bytes; LINE_SIZE_BITS = 8*LINE_SIZE_BYTES.
REQ-002 Parameter ADDRESS_WIDTH, default 32: byte address width.
REQ-003 Parameter WB_DEPTH, default 4: writeback buffer entries; power of two, at least 2.
REQ-004 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port i_miss, input, 1: cache miss level; held high until fill response is consumed.
REQ-007 Port i_miss_addr, input, ADDRESS_WIDTH: byte address of the missing access.
REQ-008 Port i_evict, input, 1: one-cycle valid for an evicted dirty line.
REQ-009 Port i_evict_addr / i_evict_data, input, ADDRESS_WIDTH / LINE_SIZE_BITS: evicted line address and contents.
REQ-010 Port o_memory_line, output, LINE_SIZE_BITS: fill data to cache.
REQ-011 Port o_memory_response, output, 1: one-cycle pulse; o_memory_line valid in the same cycle.
REQ-012 Port o_mem_req / o_mem_we, output, 1 / 1: memory request valid; write (1) or read (0).
REQ-013 Port o_mem_addr / o_mem_wdata, output, ADDRESS_WIDTH / LINE_SIZE_BITS: line-aligned request address and write data.
REQ-014 Port i_mem_ready, input, 1: memory accepts the request on a clock edge where o_mem_req=1.
REQ-015 Port i_mem_rvalid / i_mem_rdata, input, 1 / LINE_SIZE_BITS: read return.
REQ-016 Port o_wb_count, output, clog2(WB_DEPTH)+1: buffer occupancy; o_wb_full, o_wb_empty, o_busy (state != IDLE), o_wb_overflow (sticky), each output, 1.

Function
REQ-017 Line alignment: all addresses stored and compared with low clog2(LINE_SIZE_BYTES) bits forced to 0.
REQ-018 Writeback buffer: FIFO; i_evict with not full pushes {addr, data} in any state; i_evict while full drops the entry and sets o_wb_overflow.
REQ-019 Same-cycle push and pop are both performed; o_wb_count unchanged.
REQ-020 Pointers wrap modulo WB_DEPTH; o_wb_full = (count==WB_DEPTH), o_wb_empty = (count==0).
REQ-021 FSM states: IDLE, RD_REQ, RD_WAIT, RESP, WB_REQ.
REQ-022 IDLE: i_miss=1 with no hazard -> RD_REQ, capture aligned i_miss_addr; else i_miss=1 with hazard -> handled per REQ-031/032; else buffer non-empty -> WB_REQ; else stay.
REQ-023 Hazard: the aligned miss address equals the address of any valid buffer entry.
REQ-024 RD_REQ: o_mem_req=1, o_mem_we=0, o_mem_addr = captured address; on i_mem_ready -> RD_WAIT.
REQ-025 RD_WAIT: on i_mem_rvalid, register i_mem_rdata into o_memory_line -> RESP; only one read outstanding.
REQ-026 RESP: o_memory_response=1 for exactly one cycle -> IDLE.
REQ-027 WB_REQ: o_mem_req=1, o_mem_we=1, addr/wdata = FIFO head; on i_mem_ready pop head -> IDLE.
REQ-028 Request fields are stable while o_mem_req=1 and i_mem_ready=0.
REQ-029 Latency: miss seen in IDLE at cycle 0 -> o_mem_req at cycle 1; rvalid at cycle N -> o_memory_response at cycle N+1.
REQ-030 i_mem_rvalid outside RD_WAIT is ignored; o_memory_response is never asserted outside RESP, except per REQ-032.

Reset
REQ-031 With WB_FWD_EN undefined, a hazard miss drains the buffer through WB_REQ until empty, then takes RD_REQ.
REQ-032 (see Configuration) With WB_FWD_EN defined, a hazard miss forwards the youngest matching entry data to o_memory_line and pulses o_memory_response in the next cycle (RESP); no memory read; the entry stays queued.
REQ-033 rst=1 at any edge: state IDLE, FIFO emptied, o_mem_req=0, o_mem_we=0, o_memory_response=0, o_memory_line=0, o_mem_addr=0, o_mem_wdata=0, o_wb_overflow=0, o_wb_count=0.
REQ-034 Reset mid-transaction abandons the in-flight request; any later rvalid for it is ignored per REQ-030.

Configuration
REQ-035 Macro CACHE_FILL_WB_FWD_EN: defined -> forwarding per REQ-032; undefined -> drain-before-read per REQ-031, and no forwarding mux is built.

Verification
REQ-036 Clean miss: i_miss, addr 0x0000_1004, ready=1, rvalid 3 cycles later with 0xDEADBEEF -> read at 0x0000_1004, response pulse with 0xDEADBEEF 1 cycle after rvalid.
REQ-037 Drain: 3 evicts (0x100/0x11111111, 0x200/0x22222222, 0x300/0x33333333) with ready=1 -> 3 writes in FIFO order, count 3->0, empty=1.
REQ-038 Overflow and wrap: 5 back-to-back evicts with ready=0 -> full after 4, 5th dropped, overflow=1; release ready -> 4 writes in order, pointers wrapped.
REQ-039 Hazard: buffer holds 0x400/0xCAFEF00D, miss 0x400 -> without macro: write 0x400, then read 0x400; with macro: response 0xCAFEF00D in 1 cycle, no read, write still follows.
REQ-040 Reset in RD_WAIT, then stray rvalid -> no response, IDLE, all outputs at reset values.
